// File: rtl/hazard_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard sequencer.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/hazard_sequencer_fwd_select.sv
// Forwarding select for one Execute-stage source operand; Memory beats Writeback.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [3:0] i_ra,
  input  logic [3:0] i_wa_m,
  input  logic       i_we_m,
  input  logic [3:0] i_wa_w,
  input  logic       i_we_w,
  output fwd_sel_t   o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    // The PC is read from its own path, never from a forwarded result
    if (i_ra != REG_PC) begin
      if (i_we_m && (i_ra == i_wa_m)) begin
        o_sel = FWD_M;
      end else if (i_we_w && (i_ra == i_wa_w)) begin
        o_sel = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Hazard controller: forwarding, load-use stall, PC flushes and a memory-wait freeze with timeout.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchtakenE,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic       MemBusy,
  output logic       MemTimeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] LdStallCnt,
  output logic [CNT_W-1:0] MemWaitCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(MEM_TIMEOUT);

  mem_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_timeout, w_timeout_set;
  fwd_sel_t         w_fwd_a, w_fwd_b;
  logic             w_ldstall, w_pcpend, w_mem_hold;

  fwd_select u_fwd_a (
    .i_ra(RA1E), .i_wa_m(WA3M), .i_we_m(RegWriteM),
    .i_wa_w(WA3W), .i_we_w(RegWriteW), .o_sel(w_fwd_a)
  );

  fwd_select u_fwd_b (
    .i_ra(RA2E), .i_wa_m(WA3M), .i_we_m(RegWriteM),
    .i_wa_w(WA3W), .i_we_w(RegWriteW), .o_sel(w_fwd_b)
  );

  assign w_ldstall = MemtoRegE && (WA3E != REG_PC) && ((RA1D == WA3E) || (RA2D == WA3E));
  assign w_pcpend  = PCSrcD || PCSrcE || PCSrcM;
  // Freeze while an access is outstanding; the exit cycle (ready or timeout) is not frozen
  assign w_mem_hold = ((r_state == RUN)  && MemReqM && !MemReadyM) ||
                      ((r_state == WAIT) && !MemReadyM && (r_cnt != C_TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= RUN;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_timeout_set) r_timeout <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_timeout_set = 1'b0;
    case (r_state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (MemReadyM) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_TIMEOUT) begin
          w_state_nxt   = RUN;
          w_cnt_nxt     = '0;
          w_timeout_set = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = w_fwd_a;
      ForwardBE = w_fwd_b;
      if (w_mem_hold) begin
        // Branch/flush decisions wait: the frozen pipe keeps their inputs stable
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = w_ldstall || w_pcpend;
        StallD = w_ldstall;
        FlushD = w_pcpend || PCSrcW || BranchtakenE;
        FlushE = w_ldstall || BranchtakenE;
      end
    end
  end

  assign MemBusy    = (r_state == WAIT);
  assign MemTimeout = r_timeout;

`ifdef HAZARD_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != '1)) return v + 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      LdStallCnt <= '0;
      MemWaitCnt <= '0;
      FlushCnt   <= '0;
    end else begin
      LdStallCnt <= sat_inc(LdStallCnt, w_ldstall);
      MemWaitCnt <= sat_inc(MemWaitCnt, MemBusy);
      FlushCnt   <= sat_inc(FlushCnt, FlushE);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed table-driven bench for hazard_sequencer plus memory-wait, timeout and reset sequences.
module tb_hazard_sequencer;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 16;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteM, RegWriteW, MemtoRegE;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchtakenE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemBusy, MemTimeout;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] LdStallCnt, MemWaitCnt, FlushCnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchtakenE(BranchtakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemBusy(MemBusy), .MemTimeout(MemTimeout)
`ifdef HAZARD_PERF_EN
    , .LdStallCnt(LdStallCnt), .MemWaitCnt(MemWaitCnt), .FlushCnt(FlushCnt)
`endif
  );

  typedef struct {
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic rwm, rww, m2r, pcd, pce, pcm, pcw, bt;
    logic [1:0] fa, fb;
    logic sf, sd, fd, fe;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w,
                              input logic rwm, rww, m2r, pcd, pce, pcm, pcw, bt,
                              input logic [1:0] fa, fb, input logic sf, sd, fd, fe);
    vec_t v;
    v.ra1d = ra1d; v.ra2d = ra2d; v.ra1e = ra1e; v.ra2e = ra2e;
    v.wa3e = wa3e; v.wa3m = wa3m; v.wa3w = wa3w;
    v.rwm = rwm; v.rww = rww; v.m2r = m2r;
    v.pcd = pcd; v.pce = pce; v.pcm = pcm; v.pcw = pcw; v.bt = bt;
    v.fa = fa; v.fb = fb; v.sf = sf; v.sd = sd; v.fd = fd; v.fe = fe;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemBusy}
  function automatic logic [7:0] ctl();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemBusy};
  endfunction

  task automatic clear_inputs();
    RA1D = 4'd1; RA2D = 4'd2; RA1E = 4'd3; RA2E = 4'd4;
    WA3E = 4'd6; WA3M = 4'd7; WA3W = 4'd8;
    RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchtakenE = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic apply(input vec_t v);
    RA1D = v.ra1d; RA2D = v.ra2d; RA1E = v.ra1e; RA2E = v.ra2e;
    WA3E = v.wa3e; WA3M = v.wa3m; WA3W = v.wa3w;
    RegWriteM = v.rwm; RegWriteW = v.rww; MemtoRegE = v.m2r;
    PCSrcD = v.pcd; PCSrcE = v.pce; PCSrcM = v.pcm; PCSrcW = v.pcw; BranchtakenE = v.bt;
  endtask

  initial begin
    //              ra1d ra2d ra1e ra2e wa3e wa3m wa3w rwm rww m2r pcd pce pcm pcw bt  fa     fb     sf sd fd fe
    vecs[0]  = mk(1,  2,  3,  4,  6,  7,  8,  0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[1]  = mk(1,  2,  3,  4,  6,  3,  3,  1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0);
    vecs[2]  = mk(1,  2,  3,  4,  6,  3,  3,  0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0);
    vecs[3]  = mk(1,  2, 15,  4,  6, 15, 15,  1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[4]  = mk(1,  2,  5,  9,  6,  9,  9,  0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0);
    vecs[5]  = mk(1,  2,  7,  7,  6,  7,  8,  1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 0, 0, 0, 0);
    vecs[6]  = mk(1,  5,  3,  4,  5,  7,  8,  0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 1);
    vecs[7]  = mk(15, 2,  3,  4, 15,  7,  8,  0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[8]  = mk(5,  2,  3,  4,  5,  7,  8,  0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[9]  = mk(1,  2,  3,  4,  6,  7,  8,  0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 1);
    vecs[10] = mk(1,  2,  3,  4,  6,  7,  8,  0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1, 0);
    vecs[11] = mk(1,  2,  3,  4,  6,  7,  8,  0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0);
    vecs[12] = mk(5,  2,  3,  4,  5,  7,  8,  0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 1, 1, 1);
    vecs[13] = mk(1,  2,  3,  4,  6,  7,  8,  0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1, 0, 1, 0);
    vecs[14] = mk(1,  2,  3,  4,  6,  7,  8,  0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1, 0);

    clear_inputs();
    reset = 1'b0;
    #2;
    check("reset_ctl", 32'(ctl()), 32'(8'b0000_1110));
    check("reset_timeout", 32'(MemTimeout), 32'd0);
`ifdef HAZARD_PERF_EN
    check("reset_perf", {LdStallCnt, MemWaitCnt[7:0], FlushCnt[7:0]}, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Combinational forwarding / stall / flush table, RUN state, no memory access
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check($sformatf("vec%0d_fwdA", i), 32'(ForwardAE), 32'(vecs[i].fa));
      check($sformatf("vec%0d_fwdB", i), 32'(ForwardBE), 32'(vecs[i].fb));
      check($sformatf("vec%0d_ctl", i), 32'(ctl()),
            32'({vecs[i].sf, vecs[i].sd, 2'b00, vecs[i].fd, vecs[i].fe, 2'b00}));
    end

    // Memory wait: ready low 3 cycles then high; branch flush must be deferred while frozen
    @(negedge clk);
    clear_inputs();
    BranchtakenE = 1'b1;
    MemReqM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      MemReadyM = (i == 3);
      #1;
      check($sformatf("memwait%0d_ctl", i), 32'(ctl()),
            (i < 3) ? 32'({4'b1111, 2'b00, 1'b1, (i > 0)}) : 32'(8'b0000_1101));
    end
    @(negedge clk);
    MemReqM = 1'b0; MemReadyM = 1'b0; BranchtakenE = 1'b0;
    #1;
    check("memwait_done_ctl", 32'(ctl()), 32'd0);
    check("memwait_no_timeout", 32'(MemTimeout), 32'd0);

    // Same-cycle request and ready: no stall and no wait state
    MemReqM = 1'b1; MemReadyM = 1'b1;
    #1;
    check("sameready_ctl", 32'(ctl()), 32'd0);
    @(negedge clk);
    MemReqM = 1'b0;
    #1;
    check("sameready_busy", 32'(MemBusy), 32'd0);

    // Timeout: ready never comes; release on the 4th wait cycle
    @(negedge clk);
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check($sformatf("timeout%0d_ctl", i), 32'(ctl()),
            (i < 4) ? 32'({4'b1111, 3'b001, (i > 0)}) : 32'(8'b0000_0001));
      check($sformatf("timeout%0d_flag", i), 32'(MemTimeout), 32'd0);
    end
    @(negedge clk);
    MemReqM = 1'b0;
    #1;
    check("timeout_flag_set", 32'(MemTimeout), 32'd1);
    check("timeout_exit_busy", 32'(MemBusy), 32'd0);
    repeat (3) @(negedge clk);
    check("timeout_sticky", 32'(MemTimeout), 32'd1);

    // Async reset in the middle of a wait
    MemReqM = 1'b1; MemReadyM = 1'b0;
    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("prereset_busy", 32'(MemBusy), 32'd1);
    check("prereset_fwdA", 32'(ForwardAE), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_ctl", 32'(ctl()), 32'(8'b0000_1110));
    check("midreset_fwdA", 32'(ForwardAE), 32'd0);
    check("midreset_timeout", 32'(MemTimeout), 32'd0);
`ifdef HAZARD_PERF_EN
    check("midreset_perf", {LdStallCnt, MemWaitCnt[7:0], FlushCnt[7:0]}, 32'd0);
`endif
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("postreset_ctl", 32'(ctl()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline hazard controller for the 5-stage ARM pipelined core (F/D/E/M/W).
- Computes operand forwarding selects, load-use stalls and PC-write/branch flushes.
- Sequences a multi-cycle data-memory handshake by freezing the pipe until the memory completes, with a timeout.
- Sits beside the controller; drives the stage-register enables/clears of both datapath and control pipelines.

Parameters:
- MEM_TIMEOUT, 16, max wait cycles for MemReadyM before forced release (≥2).
- CNT_W, 16, width of wait counter and perf counters.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- RA1D, RA2D  in  4 each  source registers in Decode.
- RA1E, RA2E  in  4 each  source registers in Execute.
- WA3E, WA3M, WA3W  in  4 each  destination registers in E/M/W.
- RegWriteM, RegWriteW, MemtoRegE  in  1 each  control from pipeline.
- PCSrcD, PCSrcE, PCSrcM  in  1 each  in-flight PC write.
- BranchtakenE  in  1  conditional branch resolved taken.
- MemReqM  in  1  Memory stage issues a load/store this cycle.
- MemReadyM  in  1  memory completes the access (same-cycle allowed).
- ForwardAE, ForwardBE  out  2 each  00 = regfile, 01 = ResultW, 10 = ALUResultM.
- StallF, StallD, StallE, StallM  out  1 each  hold stage register.
- FlushD, FlushE, FlushW  out  1 each  clear stage register (bubble).
- MemBusy  out  1  FSM in WAIT.
- MemTimeout  out  1  sticky; a wait expired.

Behaviour:
- Forwarding, combinational: ForwardAE = 10 if RA1E==WA3M & RegWriteM; else 01 if RA1E==WA3W & RegWriteW; else 00. M has priority over W. Same for B with RA2E. Register 15 is never forwarded.
- LdStall = MemtoRegE & WA3E≠15 & (RA1D==WA3E | RA2D==WA3E).
- PCPend = PCSrcD | PCSrcE | PCSrcM.
- FSM states: RUN, WAIT.
- RUN→WAIT when MemReqM & !MemReadyM; counter loads 1.
- WAIT→RUN when MemReadyM, or when counter == MEM_TIMEOUT. The timeout sets MemTimeout and treats the access as complete.
- WAIT→WAIT otherwise; counter increments and saturates at MEM_TIMEOUT.
- Stall decision, RUN state, or WAIT exit cycle when the exit comes from MemReadyM:
  - StallF = LdStall | PCPend.
  - StallD = LdStall.
  - FlushD = PCPend | PCSrcW | BranchtakenE.
  - FlushE = LdStall | BranchtakenE.
  - StallE = StallM = FlushW = 0.
- Stall decision when MemReqM & !MemReadyM in RUN, and every WAIT cycle not exiting:
  - StallF/D/E/M = 1.
  - FlushW = 1.
  - FlushD = FlushE = 0. Branch/flush decisions are deferred; inputs are held by the stall.
- Timeout exit cycle: behaves as the RUN rules above. MemBusy = 1 iff state == WAIT.
- Same-cycle MemReqM & MemReadyM in RUN: no stall, no state change.
- LdStall and BranchtakenE together: both flush sources apply (FlushE = 1).
- Reset asserted, async, any state:
  - state = RUN, counter = 0, MemTimeout = 0.
  - All stalls = 0. FlushD = FlushE = FlushW = 1. Forward selects = 00.
- Reset deasserting mid-wait resumes in RUN with no memory state retained.
- MemTimeout clears only on reset.

Optional Feature:
- HAZARD_PERF_EN:
  - Defined: adds outputs LdStallCnt, MemWaitCnt, FlushCnt (CNT_W each). They count cycles with LdStall, cycles with MemBusy, and cycles with FlushE, respectively.
  - Counters saturate at all-ones and clear on reset.
  - Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - mem_state_t enum: RUN, WAIT.
  - Constant REG_PC = 4'd15.
- Sub-module fwd_select: the combinational forwarding for one operand, instantiated for A and B.

Test Plan:
- Forward priority: RA1E = 3, WA3M = 3, RegWriteM = 1, WA3W = 3, RegWriteW = 1 → ForwardAE = 10. Drop RegWriteM → 01. RA1E = 15 → 00.
- Load-use: MemtoRegE = 1, WA3E = 5, RA2D = 5 → StallF = StallD = FlushE = 1 for one cycle, then 0 once E advances.
- Branch: BranchtakenE = 1 → FlushD = FlushE = 1, StallF = 0. PCSrcD = 1 → StallF = FlushD = 1.
- Memory wait: MemReqM = 1 with MemReadyM low for 3 cycles then high → StallF/D/E/M and FlushW high 3 cycles, MemBusy high 3 cycles, MemTimeout = 0.
- Timeout: MemReadyM never asserts, MEM_TIMEOUT = 4 → release after 4 wait cycles, MemTimeout = 1 and sticky until reset.
- Async reset during WAIT: drive reset = 0 mid-cycle → stalls 0 and FlushD/E/W = 1 immediately, MemBusy = 0. With HAZARD_PERF_EN, counters read 0.
